// File: rtl/nn_pkg.sv
// Shared constants and types for the fully-connected layer datapath.
package nn_pkg;

   localparam int DATA_W     = 16;
   localparam int FRAC_W     = 8;
   localparam int MAC_ACC_W  = 42;

   localparam int L1_TERMS   = 784;
   localparam int L1_NEURONS = 200;
   localparam int L2_TERMS   = 200;
   localparam int L2_NEURONS = 10;

   typedef enum logic [1:0] {
      MAC_IDLE,
      MAC_ACCUM,
      MAC_DRAIN,
      MAC_DONE
   } mac_state_e;

endpackage

// File: rtl/mac_sat_scale.sv
// Combinational shift/saturate from accumulator width to DATA_W.
// Define MAC_ACCUM_ROUND_EN to round half up instead of truncating toward -inf.
module mac_sat_scale #(
   parameter int ACC_W  = nn_pkg::MAC_ACC_W,
   parameter int DATA_W = nn_pkg::DATA_W,
   parameter int FRAC_W = nn_pkg::FRAC_W
) (
   input  logic signed [ACC_W-1:0]  acc_i,
   output logic signed [DATA_W-1:0] value_o,
   output logic                     ovf_o
);

   // One guard bit keeps the rounding add from wrapping a near-max accumulator.
   localparam int EXT_W = ACC_W + 1;

   logic signed [EXT_W-1:0]      extAcc;
   logic signed [EXT_W-1:0]      shifted;
   logic        [EXT_W-DATA_W:0] upperBits;

   assign extAcc = {acc_i[ACC_W-1], acc_i};

`ifdef MAC_ACCUM_ROUND_EN
   localparam logic signed [EXT_W-1:0] HALF_LSB = EXT_W'(1) << (FRAC_W - 1);
   assign shifted = (extAcc + HALF_LSB) >>> FRAC_W;
`else
   assign shifted = extAcc >>> FRAC_W;
`endif

   // The value fits when every bit from the DATA_W sign bit upward agrees.
   assign upperBits = shifted[EXT_W-1:DATA_W-1];

   always_comb begin
      value_o = shifted[DATA_W-1:0];
      ovf_o   = 1'b0;
      if (!((upperBits == '0) || (&upperBits))) begin
         ovf_o   = 1'b1;
         value_o = shifted[EXT_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/mac_accum.sv
// Streaming multiply-accumulate: N_TERMS (x, w) pairs in, one scaled saturated result out.
// Define MAC_ACCUM_ROUND_EN for round-half-up scaling; ports and latency are unchanged.
module mac_accum #(
   parameter int DATA_W  = nn_pkg::DATA_W,
   parameter int FRAC_W  = nn_pkg::FRAC_W,
   parameter int N_TERMS = nn_pkg::L1_TERMS,
   parameter int ACC_W   = nn_pkg::MAC_ACC_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_x,
   input  logic signed [DATA_W-1:0] in_w,
   output logic signed [DATA_W-1:0] result,
   output logic                     done,
   output logic                     ovf,
   output logic                     busy
);

   import nn_pkg::*;

   localparam int CNT_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

   mac_state_e               state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic                     pvalid_q, pvalid_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] result_q, result_d;
   logic                     ovf_q, ovf_d;

   logic                     accept;
   logic signed [ACC_W-1:0]  prodExt;
   logic signed [DATA_W-1:0] scaledValue;
   logic                     scaledOvf;

   mac_sat_scale #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_sat_scale (
      .acc_i   (acc_q),
      .value_o (scaledValue),
      .ovf_o   (scaledOvf)
   );

   // A start in the same cycle wins over a pair, so nothing is accepted into a sum being cleared.
   assign in_ready = (state_q == MAC_ACCUM) && !start;
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q == MAC_ACCUM) || (state_q == MAC_DRAIN);
   assign done     = (state_q == MAC_DONE);
   assign result   = result_q;
   assign ovf      = ovf_q;
   assign prodExt  = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      pvalid_d = 1'b0;
      acc_d    = acc_q;
      result_d = result_q;
      ovf_d    = ovf_q;

      if (start) begin
         state_d = MAC_ACCUM;
         cnt_d   = '0;
         acc_d   = '0;
      end else begin
         if (pvalid_q) begin
            acc_d = acc_q + prodExt;
         end
         if (accept) begin
            prod_d   = PROD_W'(in_x) * PROD_W'(in_w);
            pvalid_d = 1'b1;
            if (cnt_q == LAST_TERM) begin
               cnt_d   = '0;
               state_d = MAC_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // DRAIN waits for the last product to land in acc before the result is captured.
         case (state_q)
            MAC_DRAIN: begin
               if (!pvalid_q) begin
                  state_d  = MAC_DONE;
                  result_d = scaledValue;
                  ovf_d    = scaledOvf;
               end
            end
            MAC_DONE: state_d = MAC_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= MAC_IDLE;
         cnt_q    <= '0;
         prod_q   <= '0;
         pvalid_q <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         pvalid_q <= pvalid_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_mac_accum.sv
// Scoreboard bench for mac_accum with N_TERMS=4; honours MAC_ACCUM_ROUND_EN in its reference model.
module tb_mac_accum;

   localparam int DATA_W  = 16;
   localparam int FRAC_W  = 8;
   localparam int N_TERMS = 4;
   localparam int ACC_W   = 42;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     start;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_x;
   logic signed [DATA_W-1:0] in_w;
   logic signed [DATA_W-1:0] result;
   logic                     done;
   logic                     ovf;
   logic                     busy;

   typedef struct {
      logic signed [DATA_W-1:0] res;
      logic                     ovf;
   } exp_t;

   exp_t                     expQ[$];
   logic signed [DATA_W-1:0] vx[N_TERMS];
   logic signed [DATA_W-1:0] vw[N_TERMS];
   int                       vgap[N_TERMS];

   int                       cyc = 0;
   int                       nAssert = 0;
   int                       nFail = 0;
   int                       lastAccept = -100;
   logic signed [DATA_W-1:0] heldRes = '0;
   logic                     heldOvf = 1'b0;
   bit                       heldValid = 1'b0;

   mac_accum #(
      .DATA_W  (DATA_W),
      .FRAC_W  (FRAC_W),
      .N_TERMS (N_TERMS),
      .ACC_W   (ACC_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_x     (in_x),
      .in_w     (in_w),
      .result   (result),
      .done     (done),
      .ovf      (ovf),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nAssert++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Dot product scaled by 2^-FRAC_W (floor, or round half up), clamped to the signed DATA_W range.
   function automatic exp_t refModel(input longint sum);
      exp_t   e;
      longint s;
      longint maxV;
      longint minV;
      maxV = (longint'(1) << (DATA_W - 1)) - 1;
      minV = -(longint'(1) << (DATA_W - 1));
      s = sum;
`ifdef MAC_ACCUM_ROUND_EN
      s = s + (longint'(1) << (FRAC_W - 1));
`endif
      s = s >>> FRAC_W;
      if (s > maxV) begin
         e.res = DATA_W'(maxV);
         e.ovf = 1'b1;
      end else if (s < minV) begin
         e.res = DATA_W'(minV);
         e.ovf = 1'b1;
      end else begin
         e.res = DATA_W'(s);
         e.ovf = 1'b0;
      end
      return e;
   endfunction

   // Monitor: pops the scoreboard on every done and otherwise insists the last result is held.
   always @(negedge clk) begin
      if (reset) begin
         heldRes   = '0;
         heldOvf   = 1'b0;
         heldValid = 1'b1;
      end else begin
         if (in_valid && in_ready) lastAccept = cyc;
         if (done) begin
            checkOutput("done_has_expectation", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("result", 32'(result), 32'(e.res));
               checkOutput("ovf", 32'(ovf), 32'(e.ovf));
               checkOutput("done_latency", 32'(cyc - lastAccept), 32'd3);
               heldRes   = e.res;
               heldOvf   = e.ovf;
               heldValid = 1'b1;
            end
         end else if (heldValid) begin
            checkOutput("result_hold", 32'(result), 32'(heldRes));
            checkOutput("ovf_hold", 32'(ovf), 32'(heldOvf));
         end
      end
   end

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic drivePair(input logic signed [DATA_W-1:0] x, input logic signed [DATA_W-1:0] w, input int gap);
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_x     = x;
      in_w     = w;
      @(negedge clk);
      checkOutput("in_ready_accum", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_x     = DATA_W'($urandom);
      in_w     = DATA_W'($urandom);
   endtask

   task automatic waitDone(input bit backToBack);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
         end else begin
            checkOutput("in_ready_low_drain", 32'(in_ready), 32'd0);
            checkOutput("busy_drain", 32'(busy), 32'd1);
         end
      end
      checkOutput("done_seen", 32'(seen), 32'd1);
      if (backToBack && seen) begin
         start = 1'b1;
      end else begin
         @(posedge clk);
         #1;
         checkOutput("busy_idle", 32'(busy), 32'd0);
         checkOutput("in_ready_idle", 32'(in_ready), 32'd0);
      end
   endtask

   task automatic applyStimulus(input bit backToBack);
      longint sum;
      sum = 0;
      pulseStart();
      for (int i = 0; i < N_TERMS; i++) begin
         drivePair(vx[i], vw[i], vgap[i]);
         sum += longint'(vx[i]) * longint'(vw[i]);
      end
      expQ.push_back(refModel(sum));
      waitDone(backToBack);
   endtask

   task automatic setVector(input logic signed [DATA_W-1:0] x0, input logic signed [DATA_W-1:0] w0,
                            input logic signed [DATA_W-1:0] xr, input logic signed [DATA_W-1:0] wr);
      vx[0] = x0;
      vw[0] = w0;
      for (int i = 1; i < N_TERMS; i++) begin
         vx[i] = xr;
         vw[i] = wr;
      end
      for (int i = 0; i < N_TERMS; i++) vgap[i] = 0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_x     = '0;
      in_w     = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_result", 32'(result), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_ovf", 32'(ovf), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // 1.0 * 2.0 four times
      setVector(16'sd256, 16'sd512, 16'sd256, 16'sd512);
      applyStimulus(1'b0);

      // Asynchronous reset in the middle of a sum, away from any clock edge
      pulseStart();
      drivePair(16'sd256, 16'sd256, 0);
      drivePair(16'sd256, 16'sd256, 0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_result", 32'(result), 32'd0);
      checkOutput("async_reset_done", 32'(done), 32'd0);
      checkOutput("async_reset_ovf", 32'(ovf), 32'd0);
      checkOutput("async_reset_busy", 32'(busy), 32'd0);
      checkOutput("async_reset_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;

      setVector(16'sd256, 16'sd256, 16'sd256, 16'sd256);
      applyStimulus(1'b0);

      // Negative products with gaps of 0, 2 and 1 idle cycles between pairs
      setVector(-16'sd256, 16'sd256, -16'sd256, 16'sd256);
      vgap[1] = 0;
      vgap[2] = 2;
      vgap[3] = 1;
      applyStimulus(1'b0);

      // Saturation both ways; the second starts during the first's done cycle
      setVector(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
      applyStimulus(1'b1);
      setVector(-16'sd32768, 16'sd32767, -16'sd32768, 16'sd32767);
      applyStimulus(1'b0);

      // Half-LSB sums: distinguish truncation from rounding
      setVector(16'sd1, 16'sd128, 16'sd0, 16'sd0);
      applyStimulus(1'b0);
      setVector(-16'sd1, 16'sd128, 16'sd0, 16'sd0);
      applyStimulus(1'b0);

      // Abort after two pairs; only the restarted sum may produce done
      pulseStart();
      drivePair(16'sd1000, 16'sd1000, 0);
      drivePair(16'sd1000, 16'sd1000, 0);
      setVector(16'sd256, 16'sd256, 16'sd256, 16'sd256);
      applyStimulus(1'b0);

      // Randomised vectors: full range, small values, near full scale
      for (int n = 0; n < 24; n++) begin
         int mode;
         mode = $urandom_range(0, 2);
         for (int i = 0; i < N_TERMS; i++) begin
            case (mode)
               0: begin
                  vx[i] = DATA_W'($urandom);
                  vw[i] = DATA_W'($urandom);
               end
               1: begin
                  vx[i] = DATA_W'(int'($urandom_range(0, 1023)) - 512);
                  vw[i] = DATA_W'(int'($urandom_range(0, 1023)) - 512);
               end
               default: begin
                  vx[i] = DATA_W'(int'($urandom_range(0, 511)) + 32256);
                  vw[i] = ($urandom_range(0, 1) == 1) ? -16'sd32768 : 16'sd32767;
               end
            endcase
            vgap[i] = $urandom_range(0, 2);
         end
         applyStimulus((n != 23) && ($urandom_range(0, 1) == 1));
      end

      repeat (5) @(posedge clk);
      #1;
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
